// File: rtl/peripheral_master_wb_engine.sv
// Wishbone burst master engine: accepts a command (read/write, start
// address, byte select, beat count), runs it as an incrementing burst on
// a Wishbone B4 bus with per-beat retry handling, returns read beats on
// the rsp channel and signals completion with done/done_err.
// Ports:
//   wb_clk, wb_rst                     clock, async active-high reset
//   cmd_*                              command handshake and payload
//   wdat_valid/wdat_ready/wdat         write-data handshake (one per beat)
//   rsp_valid/rsp_data/rsp_last        read-beat strobe, no backpressure
//   done/done_err                      command completion strobe
//   wb_*_o / wb_*_i                    Wishbone master interface
module peripheral_master_wb_engine #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 32,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_adr,
    input  logic [DW/8-1:0]   cmd_sel,
    input  logic [3:0]        cmd_len,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [DW-1:0]     wdat,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_last,
    output logic              done,
    output logic              done_err,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned RW = $clog2(RETRY_MAX + 2);

    typedef enum logic [2:0] {IDLE, FETCH, BUS, WAIT, DONE} state_t;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [RW-1:0]   rty_cnt, rty_n;
    logic            err, err_n;
    logic            we_n;
    logic [AW-1:0]   adr_n;
    logic [SW-1:0]   sel_n;
    logic [DW-1:0]   dat_n;
    logic            rsp_valid_n, rsp_last_n;
    logic [DW-1:0]   rsp_data_n;
    logic            cmd_ready_n, wdat_ready_n, cyc_n, stb_n, done_n, done_err_n;
    logic [2:0]      cti_n;

    // Linear burst only
    assign wb_bte_o = 2'b00;

    // State and registered outputs; reset drops cyc/stb immediately
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rty_cnt    <= '0;
            err        <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_sel_o   <= '0;
            wb_dat_o   <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            cmd_ready  <= 1'b0;
            wdat_ready <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cti_o   <= 3'b000;
            done       <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rty_cnt    <= rty_n;
            err        <= err_n;
            wb_we_o    <= we_n;
            wb_adr_o   <= adr_n;
            wb_sel_o   <= sel_n;
            wb_dat_o   <= dat_n;
            rsp_valid  <= rsp_valid_n;
            rsp_data   <= rsp_data_n;
            rsp_last   <= rsp_last_n;
            cmd_ready  <= cmd_ready_n;
            wdat_ready <= wdat_ready_n;
            wb_cyc_o   <= cyc_n;
            wb_stb_o   <= stb_n;
            wb_cti_o   <= cti_n;
            done       <= done_n;
            done_err   <= done_err_n;
        end
    end

    // Next state; outputs are decoded from the next state so they are
    // registered yet aligned with the state they describe
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rty_n       = rty_cnt;
        err_n       = err;
        we_n        = wb_we_o;
        adr_n       = wb_adr_o;
        sel_n       = wb_sel_o;
        dat_n       = wb_dat_o;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        rsp_last_n  = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    we_n    = cmd_we;
                    adr_n   = cmd_adr;
                    sel_n   = cmd_sel;
                    cnt_n   = cmd_len;
                    rty_n   = '0;
                    err_n   = 1'b0;
                    state_n = cmd_we ? FETCH : BUS;
                end
            end
            FETCH: begin
                if (wdat_valid && wdat_ready) begin
                    dat_n   = wdat;
                    state_n = BUS;
                end
            end
            BUS: begin
                // Responses only count while strobing; err > ack > rty,
                // and a rty past the retry budget is promoted to err
                if (wb_stb_o) begin
                    if (wb_err_i || (!wb_ack_i && wb_rty_i && rty_cnt == RW'(RETRY_MAX))) begin
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else if (wb_ack_i) begin
                        rty_n = '0;
                        if (!wb_we_o) begin
                            rsp_valid_n = 1'b1;
                            rsp_data_n  = wb_dat_i;
                            rsp_last_n  = (cnt == 4'd0);
                        end
                        if (cnt == 4'd0) begin
                            state_n = DONE;
                        end else begin
                            adr_n   = wb_adr_o + AW'(SW);
                            cnt_n   = cnt - 4'd1;
                            state_n = wb_we_o ? FETCH : BUS;
                        end
                    end else if (wb_rty_i) begin
                        rty_n   = rty_cnt + RW'(1);
                        state_n = WAIT;
                    end
                end
            end
            WAIT:    state_n = BUS;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        cmd_ready_n  = (state_n == IDLE);
        wdat_ready_n = (state_n == FETCH);
        cyc_n        = (state_n == FETCH) || (state_n == BUS) || (state_n == WAIT);
        stb_n        = (state_n == BUS);
        done_n       = (state_n == DONE);
        done_err_n   = (state_n == DONE) && err_n;
        cti_n        = cyc_n ? ((cnt_n == 4'd0) ? 3'b111 : 3'b010) : 3'b000;
    end

endmodule

// File: tb/tb_peripheral_master_wb_engine.sv
// Self-checking bench for peripheral_master_wb_engine: scripted Wishbone
// slave, write-data source with stalls, and scoreboard queues for bus
// beats, read responses and completion status.
module tb_peripheral_master_wb_engine;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic            wb_clk = 1'b0;
    logic            wb_rst;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_adr;
    logic [DW/8-1:0] cmd_sel;
    logic [3:0]      cmd_len;
    logic            wdat_valid, wdat_ready;
    logic [DW-1:0]   wdat;
    logic            rsp_valid, rsp_last, done, done_err;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i, wb_err_i, wb_rty_i;

    peripheral_master_wb_engine #(.DW(DW), .AW(AW), .RETRY_MAX(3)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .done(done), .done_err(done_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    typedef struct {
        int          kind;   // 0 ack, 1 err, 2 rty
        logic [31:0] data;
    } resp_t;

    beat_t       exp_beats[$];
    logic [32:0] exp_rsp[$];
    logic        exp_done_err[$];
    resp_t       resp_q[$];
    logic [31:0] wd_q[$];
    int          wd_stall[$];

    int n_assert = 0;
    int n_fail   = 0;
    int stb_cycles = 0;
    int done_cnt   = 0;
    int stall_seen = 0;
    bit bus_chk    = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave, write-data source and scoreboard, all on the falling edge
    always @(negedge wb_clk) begin
        resp_t r;
        beat_t b;
        logic [32:0] er;
        int s;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (wb_stb_o) begin
            stb_cycles++;
            r.kind = 0;
            r.data = 32'h0;
            if (resp_q.size() > 0) r = resp_q.pop_front();
            if (bus_chk) begin
                if (exp_beats.size() == 0) begin
                    chk("unexpected_beat", 64'(wb_adr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat_adr", 64'(wb_adr_o), 64'(b.adr));
                    chk("beat_we",  64'(wb_we_o),  64'(b.we));
                    chk("beat_cti", 64'(wb_cti_o), 64'(b.cti));
                    chk("beat_sel", 64'(wb_sel_o), 64'(4'hF));
                    if (b.we) chk("beat_dat", 64'(wb_dat_o), 64'(b.dat));
                end
            end
            wb_ack_i = (r.kind == 0);
            wb_err_i = (r.kind == 1);
            wb_rty_i = (r.kind == 2);
            wb_dat_i = r.data;
        end
        if (rsp_valid && bus_chk) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp", 64'({rsp_last, rsp_data}), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                er = exp_rsp.pop_front();
                chk("rsp", 64'({rsp_last, rsp_data}), 64'(er));
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_bus_idle", 64'({wb_cyc_o, wb_stb_o}), 64'(2'b00));
            if (exp_done_err.size() == 0)
                chk("unexpected_done", 64'(done_err), 64'hFF);
            else
                chk("done_err", 64'(done_err), 64'(exp_done_err.pop_front()));
        end
        wdat_valid = 1'b0;
        if (wdat_ready && wd_q.size() > 0) begin
            if (wd_stall.size() > 0 && wd_stall[0] > 0) begin
                s = wd_stall[0];
                wd_stall[0] = s - 1;
                stall_seen++;
                chk("stall_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'(2'b10));
            end else begin
                wdat_valid = 1'b1;
                wdat = wd_q.pop_front();
                if (wd_stall.size() > 0) void'(wd_stall.pop_front());
            end
        end
    end

    task automatic push_beat(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [2:0] cti);
        beat_t b;
        b.adr = adr; b.we = we; b.dat = dat; b.cti = cti;
        exp_beats.push_back(b);
    endtask

    task automatic push_resp(input int kind, input logic [31:0] data);
        resp_t r;
        r.kind = kind; r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len);
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge wb_clk);
            t++;
        end
        chk("cmd_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = 4'hF; cmd_len = len;
        @(negedge wb_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(negedge wb_clk);
            t++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt - d0), 64'(1));
        repeat (2) @(negedge wb_clk);
        chk({tag, "_beats_left"}, 64'(exp_beats.size()), 64'(0));
        chk({tag, "_rsp_left"}, 64'(exp_rsp.size()), 64'(0));
        chk({tag, "_done_left"}, 64'(exp_done_err.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s0;
        wb_rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
        wdat_valid = 1'b0; wdat = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;

        // Reset values
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_cyc_stb",   64'({wb_cyc_o, wb_stb_o}), 64'(0));
        chk("rst_cti",       64'(wb_cti_o), 64'(0));
        chk("rst_rsp_done",  64'({rsp_valid, done, done_err}), 64'(0));
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
        #1 chk("rel_cmd_ready_pre_edge", 64'(cmd_ready), 64'(0));
        @(negedge wb_clk);
        chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));

        // Single read with minimum latency
        d0 = done_cnt; s0 = stb_cycles;
        push_beat(32'h100, 1'b0, 32'h0, 3'b111);
        push_resp(0, 32'hDEADBEEF);
        exp_rsp.push_back({1'b1, 32'hDEADBEEF});
        exp_done_err.push_back(1'b0);
        send_cmd(1'b0, 32'h100, 4'd0);
        chk("t1_stb_latency", 64'(wb_stb_o), 64'(1));
        @(negedge wb_clk);
        chk("t1_rsp_latency", 64'(rsp_valid), 64'(1));
        wait_done("t1", d0);
        chk("t1_stb_cycles", 64'(stb_cycles - s0), 64'(1));

        // Four-beat read, zero-wait slave, back-to-back beats
        d0 = done_cnt; s0 = stb_cycles;
        for (int i = 0; i < 4; i++) begin
            push_beat(32'h200 + 32'(4 * i), 1'b0, 32'h0, (i == 3) ? 3'b111 : 3'b010);
            push_resp(0, 32'hA000_0000 + 32'(i));
            exp_rsp.push_back({(i == 3), 32'hA000_0000 + 32'(i)});
        end
        exp_done_err.push_back(1'b0);
        send_cmd(1'b0, 32'h200, 4'd3);
        for (int i = 0; i < 4; i++) begin
            chk("t2_stb_consecutive", 64'(wb_stb_o), 64'(1));
            @(negedge wb_clk);
        end
        wait_done("t2", d0);
        chk("t2_stb_cycles", 64'(stb_cycles - s0), 64'(4));

        // Three-beat write with a 3-cycle data stall before the last beat
        d0 = done_cnt; s0 = stall_seen;
        push_beat(32'h300, 1'b1, 32'h1111_AAAA, 3'b010);
        push_beat(32'h304, 1'b1, 32'h2222_BBBB, 3'b010);
        push_beat(32'h308, 1'b1, 32'h3333_CCCC, 3'b111);
        for (int i = 0; i < 3; i++) push_resp(0, 32'h0);
        wd_q.push_back(32'h1111_AAAA); wd_stall.push_back(0);
        wd_q.push_back(32'h2222_BBBB); wd_stall.push_back(0);
        wd_q.push_back(32'h3333_CCCC); wd_stall.push_back(3);
        exp_done_err.push_back(1'b0);
        send_cmd(1'b1, 32'h300, 4'd2);
        wait_done("t3", d0);
        chk("t3_stall_cycles", 64'(stall_seen - s0), 64'(3));

        // Read burst ended by a bus error on the third beat
        d0 = done_cnt; s0 = stb_cycles;
        push_beat(32'h400, 1'b0, 32'h0, 3'b010);
        push_beat(32'h404, 1'b0, 32'h0, 3'b010);
        push_beat(32'h408, 1'b0, 32'h0, 3'b010);
        push_resp(0, 32'hB0); push_resp(0, 32'hB1); push_resp(1, 32'hB2);
        exp_rsp.push_back({1'b0, 32'hB0});
        exp_rsp.push_back({1'b0, 32'hB1});
        exp_done_err.push_back(1'b1);
        send_cmd(1'b0, 32'h400, 4'd3);
        wait_done("t4", d0);
        chk("t4_stb_cycles", 64'(stb_cycles - s0), 64'(3));

        // Single write: two retries then ack
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) push_beat(32'h500, 1'b1, 32'h55AA_55AA, 3'b111);
        push_resp(2, 0); push_resp(2, 0); push_resp(0, 0);
        wd_q.push_back(32'h55AA_55AA);
        exp_done_err.push_back(1'b0);
        send_cmd(1'b1, 32'h500, 4'd0);
        wait_done("t5", d0);

        // Single write: four retries exceed the budget
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) push_beat(32'h504, 1'b1, 32'h1234_5678, 3'b111);
        for (int i = 0; i < 4; i++) push_resp(2, 0);
        wd_q.push_back(32'h1234_5678);
        exp_done_err.push_back(1'b1);
        send_cmd(1'b1, 32'h504, 4'd0);
        wait_done("t6", d0);

        // Ack resets the retry budget: three retries on each of two beats
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) push_beat(32'h700, 1'b0, 32'h0, 3'b010);
        for (int i = 0; i < 4; i++) push_beat(32'h704, 1'b0, 32'h0, 3'b111);
        for (int i = 0; i < 3; i++) push_resp(2, 0);
        push_resp(0, 32'hC0);
        for (int i = 0; i < 3; i++) push_resp(2, 0);
        push_resp(0, 32'hC1);
        exp_rsp.push_back({1'b0, 32'hC0});
        exp_rsp.push_back({1'b1, 32'hC1});
        exp_done_err.push_back(1'b0);
        send_cmd(1'b0, 32'h700, 4'd1);
        wait_done("t7", d0);

        // Address wraps modulo 2^AW
        d0 = done_cnt;
        push_beat(32'hFFFF_FFFC, 1'b0, 32'h0, 3'b010);
        push_beat(32'h0000_0000, 1'b0, 32'h0, 3'b111);
        push_resp(0, 32'hD0); push_resp(0, 32'hD1);
        exp_rsp.push_back({1'b0, 32'hD0});
        exp_rsp.push_back({1'b1, 32'hD1});
        exp_done_err.push_back(1'b0);
        send_cmd(1'b0, 32'hFFFF_FFFC, 4'd1);
        wait_done("t8", d0);

        // Reset during the second beat of a four-beat read
        d0 = done_cnt;
        bus_chk = 1'b0;
        for (int i = 0; i < 4; i++) push_resp(0, 32'hE0 + 32'(i));
        send_cmd(1'b0, 32'h600, 4'd3);
        for (int t = 0; t < 20 && !(wb_stb_o && wb_adr_o == 32'h604); t++) @(negedge wb_clk);
        chk("t9_reached_beat2", 64'(wb_adr_o), 64'(32'h604));
        #2 wb_rst = 1'b1;
        #1;
        chk("t9_async_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        chk("t9_cmd_ready_in_rst", 64'(cmd_ready), 64'(0));
        repeat (2) @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        chk("t9_cmd_ready_after", 64'(cmd_ready), 64'(1));
        repeat (3) @(negedge wb_clk);
        chk("t9_no_done", 64'(done_cnt - d0), 64'(0));
        resp_q.delete();
        bus_chk = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_master_wb_engine.md
PERIPHERAL_MASTER_WB_ENGINE -- requirements
Module: peripheral_master_wb_engine

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the Wishbone data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter AW, default 32, meaning the Wishbone address width in bits.
REQ-003 The block SHALL have parameter RETRY_MAX, default 3, meaning the consecutive wb_rty_i responses tolerated per beat before the beat errors.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; port list:
  wb_clk  in  1  clock, all logic on rising edge
  wb_rst  in  1  asynchronous active-high reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when both high at an edge
  cmd_we  in  1  1=write, 0=read
  cmd_adr  in  AW  start byte address
  cmd_sel  in  DW/8  byte select, all beats
  cmd_len  in  4  beats minus one (0..15)
  wdat_valid / wdat_ready  in / out  1  write-data handshake
  wdat  in  DW  write beat data
  rsp_valid  out  1  one-cycle read-beat strobe
  rsp_data  out  DW  read beat data
  rsp_last  out  1  final read beat
  done  out  1  one-cycle command-complete strobe
  done_err  out  1  command ended in error, valid with done
  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o[2:0], wb_bte_o[1:0]  out  Wishbone master outputs
  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i  in  Wishbone slave responses

Function
REQ-005 States SHALL be IDLE, FETCH, BUS, WAIT, DONE; cmd_ready SHALL be 1 only in IDLE and 0 while wb_rst is high.
REQ-006 On command accept, the block SHALL latch we, adr, sel, len and load a beat counter with cmd_len; next state is BUS for reads, FETCH for writes.
REQ-007 FETCH: wdat_ready=1, wb_cyc_o=1, wb_stb_o=0; on wdat_valid&&wdat_ready, wdat SHALL be registered into wb_dat_o and the state SHALL move to BUS.
REQ-008 BUS: wb_cyc_o=1, wb_stb_o=1; wb_adr_o, wb_sel_o, wb_we_o SHALL be stable until the beat terminates.
REQ-009 wb_cti_o SHALL be 3'b111 on the last beat (counter==0, including single-beat commands) and 3'b010 otherwise; wb_bte_o SHALL be 2'b00.
REQ-010 Beat termination SHALL be sampled at an edge in BUS with priority wb_err_i > wb_ack_i > wb_rty_i.
REQ-011 On ack of a non-last beat, address SHALL increment by DW/8 modulo 2^AW, counter SHALL decrement, and the next state SHALL be BUS (read, back-to-back) or FETCH (write).
REQ-012 On read ack, rsp_valid SHALL pulse the next cycle with rsp_data=wb_dat_i as sampled and rsp_last=1 on the final beat; rsp has no backpressure.
REQ-013 On ack of the last beat, the next state SHALL be DONE.
REQ-014 On wb_rty_i, the retry counter SHALL increment and the state SHALL go to WAIT (cyc=1, stb=0) for one cycle, then reissue the same beat in BUS with unchanged adr/data.
REQ-015 The retry counter SHALL clear on every ack; a rty arriving when the counter equals RETRY_MAX SHALL be treated as wb_err_i.
REQ-016 On error, the burst SHALL terminate immediately, the next state SHALL be DONE, and remaining write beats SHALL NOT be requested (upstream discards them).
REQ-017 In DONE, wb_cyc_o=0, wb_stb_o=0, done=1 and done_err=(error occurred), for exactly one cycle, then IDLE.
REQ-018 wb_ack_i/wb_err_i/wb_rty_i SHALL be ignored when wb_stb_o is 0.
REQ-019 Minimum read latency: accept at edge N, stb high during N+1, first rsp_valid at N+2 with zero-wait slave.

Reset
REQ-020 wb_rst high SHALL force IDLE and clear all counters; every output SHALL be 0 (including wb_cyc_o, wb_stb_o, wb_cti_o, rsp_valid, done) until the edge after reset release.
REQ-021 Reset asserted mid-burst SHALL drop wb_cyc_o/wb_stb_o asynchronously with no done pulse.

Verification
REQ-022 Single read adr=0x100, len=0, slave acks data 0xDEADBEEF -> one stb cycle, cti=3'b111, rsp_valid with 0xDEADBEEF, rsp_last=1, done=1, done_err=0.
REQ-023 Read adr=0x200, len=3, zero-wait slave -> addresses 0x200/0x204/0x208/0x20C on consecutive cycles, cti 010,010,010,111, four rsp_valid, last flagged.
REQ-024 Write len=2 with wdat_valid low for 3 cycles before beat 2 -> cyc held high, stb low during stall, three writes of correct data/address, done_err=0.
REQ-025 Read len=3, wb_err_i on beat 2 -> two rsp_valid (no rsp_last), cyc drops next cycle, done=1, done_err=1.
REQ-026 Single write with rty twice then ack -> beat issued 3 times, same adr/data, done_err=0; rty 4 times (RETRY_MAX=3) -> done_err=1.
REQ-027 Reset asserted during beat 2 of a 4-beat read -> cyc/stb 0 immediately, no done, cmd_ready=1 one cycle after release.
